// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths and types for the register file and ALU
package cpu_pkg;
  localparam int DATA_W = 8;
  localparam int REG_ADDR_W = 3;
  localparam int REG_COUNT = 8;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg_file_rdport.sv
// reg_file_rdport: one combinational read port with optional write-through (REG_FILE_BYPASS_EN)
module reg_file_rdport
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = REG_COUNT,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [ADDR_W-1:0]           addr,
  input  logic                        byp,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            data
);
`ifdef REG_FILE_BYPASS_EN
  assign data = (byp && addr == wr_addr) ? wr_data : regs[addr];
`else
  logic unused_byp;
  assign unused_byp = &{1'b0, byp, wr_addr, wr_data};
  assign data = regs[addr];
`endif
endmodule

// File: rtl/reg_file.sv
// reg_file: 8x8 register file with zero-flag capture; REG_FILE_BYPASS_EN adds write-through reads
module reg_file
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = REG_COUNT,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WIDTH-1:0]  IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic              ZERO_IN,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [WIDTH-1:0]  OUT1,
  output logic [WIDTH-1:0]  OUT2,
  output logic              ZFLAG
);
  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic byp;
  assign byp = WRITE & ~RESET;
  always_ff @(posedge CLK)
    if (RESET) begin
      regs  <= '0;
      ZFLAG <= 1'b0;
    end else if (WRITE) begin
      regs[INADDRESS] <= IN;
      ZFLAG           <= ZERO_IN;
    end
  reg_file_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd1 (
    .regs(regs), .addr(OUT1ADDRESS), .byp(byp), .wr_addr(INADDRESS), .wr_data(IN), .data(OUT1)
  );
  reg_file_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd2 (
    .regs(regs), .addr(OUT2ADDRESS), .byp(byp), .wr_addr(INADDRESS), .wr_data(IN), .data(OUT2)
  );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file
module tb_reg_file;
  logic       clk = 0;
  logic       rst = 1;
  logic [7:0] in_data = 0;
  logic [2:0] in_addr = 0;
  logic       write = 0;
  logic       zero_in = 0;
  logic [2:0] a1 = 0, a2 = 0;
  logic [7:0] out1, out2;
  logic       zflag;
  int checks = 0, fails = 0;

  reg_file dut (
    .CLK(clk), .RESET(rst), .IN(in_data), .INADDRESS(in_addr), .WRITE(write),
    .ZERO_IN(zero_in), .OUT1ADDRESS(a1), .OUT2ADDRESS(a2), .OUT1(out1), .OUT2(out2), .ZFLAG(zflag)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic z);
    in_addr = a; in_data = d; zero_in = z; write = 1;
    @(posedge clk); #1;
    write = 0;
  endtask

  task automatic test_reset;
    wr(3'd3, 8'hA5, 1'b1);
    a1 = 3; #1;
    checks++; if (out1 !== 8'hA5) begin fails++; $display("FAIL pre_reset_r3 got %h want a5", out1); end
    checks++; if (zflag !== 1'b1) begin fails++; $display("FAIL pre_reset_zflag got %b want 1", zflag); end
    rst = 1; @(posedge clk); #1; rst = 0;
    for (int i = 0; i < 8; i++) begin
      a1 = 3'(i); a2 = 3'(i); #1;
      checks++; if (out1 !== 8'h00 || out2 !== 8'h00) begin fails++; $display("FAIL reset_r%0d got %h/%h want 00", i, out1, out2); end
    end
    checks++; if (zflag !== 1'b0) begin fails++; $display("FAIL reset_zflag got %b want 0", zflag); end
  endtask

  task automatic test_write_read;
    for (int i = 0; i < 8; i++) wr(3'(i), 8'h10 + 8'(i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      a1 = 3'(i); a2 = 3'(7 - i); #1;
      checks++; if (out1 !== 8'h10 + 8'(i)) begin fails++; $display("FAIL rd1_r%0d got %h want %h", i, out1, 8'h10 + 8'(i)); end
      checks++; if (out2 !== 8'h17 - 8'(i)) begin fails++; $display("FAIL rd2_r%0d got %h want %h", 7 - i, out2, 8'h17 - 8'(i)); end
    end
    a1 = 6; a2 = 6; #1;
    checks++; if (out1 !== out2 || out2 !== 8'h16) begin fails++; $display("FAIL same_addr got %h/%h want 16", out1, out2); end
    checks++; if (zflag !== 1'b0) begin fails++; $display("FAIL wr_zflag got %b want 0", zflag); end
  endtask

  task automatic test_write_disabled;
    write = 0; in_data = 8'hFF; in_addr = 2; zero_in = 1;
    repeat (3) @(posedge clk);
    #1; a1 = 2; #1;
    checks++; if (out1 !== 8'h12) begin fails++; $display("FAIL nowrite_r2 got %h want 12", out1); end
    checks++; if (zflag !== 1'b0) begin fails++; $display("FAIL nowrite_zflag got %b want 0", zflag); end
  endtask

  task automatic test_flag;
    wr(3'd1, 8'h00, 1'b1);
    a1 = 1; #1;
    checks++; if (zflag !== 1'b1) begin fails++; $display("FAIL flag_set got %b want 1", zflag); end
    checks++; if (out1 !== 8'h00) begin fails++; $display("FAIL flag_r1 got %h want 00", out1); end
    wr(3'd1, 8'h11, 1'b0);
    checks++; if (zflag !== 1'b0) begin fails++; $display("FAIL flag_clear got %b want 0", zflag); end
    zero_in = 1; @(posedge clk); #1;
    checks++; if (zflag !== 1'b0) begin fails++; $display("FAIL flag_hold got %b want 0", zflag); end
  endtask

  task automatic test_reset_priority;
    rst = 1; write = 1; in_data = 8'h5A; in_addr = 4; zero_in = 1;
    @(posedge clk); #1;
    rst = 0; write = 0; a1 = 4; a2 = 7; #1;
    checks++; if (out1 !== 8'h00 || out2 !== 8'h00) begin fails++; $display("FAIL rst_prio got %h/%h want 00", out1, out2); end
    checks++; if (zflag !== 1'b0) begin fails++; $display("FAIL rst_prio_zflag got %b want 0", zflag); end
    wr(3'd4, 8'h5A, 1'b0);
    checks++; if (out1 !== 8'h5A) begin fails++; $display("FAIL resume_r4 got %h want 5a", out1); end
  endtask

  task automatic test_same_cycle;
    logic [7:0] exp_pre;
`ifdef REG_FILE_BYPASS_EN
    exp_pre = 8'h99;
`else
    exp_pre = 8'h15;
`endif
    wr(3'd5, 8'h15, 1'b0);
    a1 = 5; a2 = 3; in_addr = 5; in_data = 8'h99; write = 1; #1;
    checks++; if (out1 !== exp_pre) begin fails++; $display("FAIL rw_pre got %h want %h", out1, exp_pre); end
    checks++; if (out2 !== 8'h00) begin fails++; $display("FAIL rw_other_port got %h want 00", out2); end
    @(posedge clk); #1; write = 0; #1;
    checks++; if (out1 !== 8'h99) begin fails++; $display("FAIL rw_post got %h want 99", out1); end
    rst = 1; write = 1; in_addr = 5; in_data = 8'h77; #1;
    checks++; if (out1 !== 8'h99) begin fails++; $display("FAIL rst_no_bypass got %h want 99", out1); end
    @(posedge clk); #1; rst = 0; write = 0; #1;
    checks++; if (out1 !== 8'h00) begin fails++; $display("FAIL rst_final got %h want 00", out1); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1; rst = 0;
    test_reset;
    test_write_read;
    test_write_disabled;
    test_flag;
    test_reset_priority;
    test_same_cycle;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
